// File: rtl/score_text_pkg.sv
// Shared types and constants for the score text line fetcher and its pixel serializer.
package score_text_pkg;

  localparam int unsigned CHAR_W = 8;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned LINE_W = 3;

  localparam logic [CHAR_W-1:0] ROM_ERR_LINE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_READY = 2'd2,
    ST_SHIFT = 2'd3
  } state_e;

  // Index width that stays legal for a single-entry range.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/score_pixel_serializer.sv
// Walks the line buffer slot by slot, LSB first, holding each font pixel for
// 2**SCALE_LOG2 pixel_en strobes; done_c_o flags the final strobe of the line.
module score_pixel_serializer
  import score_text_pkg::*;
#(
  parameter int unsigned NUM_CHARS  = 4,
  parameter int unsigned SCALE_LOG2 = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic                        run_i,
  input  logic                        pixel_en_i,
  input  logic [NUM_CHARS*CHAR_W-1:0] line_buf_i,
  output logic                        pixel_c_o,
  output logic                        done_c_o
);

  localparam int unsigned SLOT_W    = idx_w(NUM_CHARS);
  localparam int unsigned BIT_W     = idx_w(CHAR_W);
  localparam int unsigned SCALE_W   = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
  localparam int unsigned SCALE_MAX = (1 << SCALE_LOG2) - 1;

  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [SCALE_W-1:0] scale_q, scale_d;
  logic               scale_last, bit_last, slot_last;
  logic [CHAR_W-1:0]  cur_line;

  assign scale_last = (scale_q == SCALE_W'(SCALE_MAX));
  assign bit_last   = (bit_q == BIT_W'(CHAR_W - 1));
  assign slot_last  = (slot_q == SLOT_W'(NUM_CHARS - 1));

  always_comb begin
    slot_d  = slot_q;
    bit_d   = bit_q;
    scale_d = scale_q;
    if (start_i) begin
      slot_d  = '0;
      bit_d   = '0;
      scale_d = '0;
    end else if (run_i && pixel_en_i) begin
      scale_d = scale_last ? '0 : scale_q + 1'b1;
      if (scale_last) begin
        bit_d = bit_last ? '0 : bit_q + 1'b1;
        if (bit_last) begin
          slot_d = slot_last ? '0 : slot_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= '0;
      bit_q   <= '0;
      scale_q <= '0;
    end else begin
      slot_q  <= slot_d;
      bit_q   <= bit_d;
      scale_q <= scale_d;
    end
  end

  assign cur_line  = line_buf_i[CHAR_W*slot_q +: CHAR_W];
  assign pixel_c_o = cur_line[bit_q];
  assign done_c_o  = run_i & pixel_en_i & scale_last & bit_last & slot_last;

endmodule

// File: rtl/score_line_fetcher.sv
// Fetches one font row per score digit from the character ROM during blanking and
// streams it out as pixels. Optional macro SCORE_BLANK_LEADING_ZERO_EN darkens leading zeros.
module score_line_fetcher
  import score_text_pkg::*;
#(
  parameter int unsigned NUM_CHARS  = 4,
  parameter int unsigned SCALE_LOG2 = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        line_start,
  input  logic                        text_row,
  input  logic [LINE_W-1:0]           font_line,
  input  logic [NUM_CHARS*CODE_W-1:0] char_codes,
  input  logic                        display_start,
  input  logic                        pixel_en,
  output logic [CODE_W-1:0]           rom_number,
  output logic [LINE_W-1:0]           rom_line,
  input  logic [CHAR_W-1:0]           rom_charline,
  output logic                        pixel_out,
  output logic                        busy
);

  localparam int unsigned SLOT_W = idx_w(NUM_CHARS);

  state_e                      state_q, state_d;
  logic [NUM_CHARS*CODE_W-1:0] codes_q, codes_d;
  logic [NUM_CHARS*CHAR_W-1:0] buf_q, buf_d;
  logic [SLOT_W-1:0]           fslot_q, fslot_d, nxt_slot;
  logic [CODE_W-1:0]           rom_number_q, rom_number_d;
  logic [LINE_W-1:0]           rom_line_q, rom_line_d;
  logic                        busy_q, busy_d;
  logic                        fetch_last, blank;
  logic                        ser_start, ser_run, ser_pixel, ser_done;

  assign nxt_slot   = fslot_q + 1'b1;
  assign fetch_last = (fslot_q == SLOT_W'(NUM_CHARS - 1));

`ifdef SCORE_BLANK_LEADING_ZERO_EN
  logic              seen_nz_q, seen_nz_d;
  logic [CODE_W-1:0] cur_code;
  // Blank zeros until the first non-zero digit; the units slot always shows.
  assign cur_code = codes_q[CODE_W*fslot_q +: CODE_W];
  assign blank    = !seen_nz_q && (cur_code == '0) && !fetch_last;
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    codes_d      = codes_q;
    buf_d        = buf_q;
    fslot_d      = fslot_q;
    rom_number_d = rom_number_q;
    rom_line_d   = rom_line_q;
`ifdef SCORE_BLANK_LEADING_ZERO_EN
    seen_nz_d    = seen_nz_q;
`endif
    case (state_q)
      ST_FETCH: begin
        buf_d[CHAR_W*fslot_q +: CHAR_W] = blank ? '0 : rom_charline;
`ifdef SCORE_BLANK_LEADING_ZERO_EN
        seen_nz_d = seen_nz_q | (cur_code != '0);
`endif
        if (fetch_last) begin
          state_d = ST_READY;
        end else begin
          fslot_d      = nxt_slot;
          rom_number_d = codes_q[CODE_W*nxt_slot +: CODE_W];
        end
      end
      ST_READY: if (display_start) state_d = ST_SHIFT;
      ST_SHIFT: if (ser_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // A new line always aborts whatever is in flight.
    if (line_start) begin
      codes_d = char_codes;
      fslot_d = '0;
`ifdef SCORE_BLANK_LEADING_ZERO_EN
      seen_nz_d = 1'b0;
`endif
      if (text_row) begin
        state_d      = ST_FETCH;
        rom_number_d = char_codes[CODE_W-1:0];
        rom_line_d   = font_line;
      end else begin
        state_d = ST_IDLE;
      end
    end
    busy_d = (state_d == ST_FETCH) || (state_d == ST_SHIFT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      codes_q      <= '0;
      buf_q        <= '0;
      fslot_q      <= '0;
      rom_number_q <= '0;
      rom_line_q   <= '0;
      busy_q       <= 1'b0;
`ifdef SCORE_BLANK_LEADING_ZERO_EN
      seen_nz_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      codes_q      <= codes_d;
      buf_q        <= buf_d;
      fslot_q      <= fslot_d;
      rom_number_q <= rom_number_d;
      rom_line_q   <= rom_line_d;
      busy_q       <= busy_d;
`ifdef SCORE_BLANK_LEADING_ZERO_EN
      seen_nz_q    <= seen_nz_d;
`endif
    end
  end

  assign ser_start = (state_q == ST_READY) && display_start && !line_start;
  assign ser_run   = (state_q == ST_SHIFT);

  score_pixel_serializer #(
    .NUM_CHARS (NUM_CHARS),
    .SCALE_LOG2(SCALE_LOG2)
  ) u_serializer (
    .clk       (clk),
    .rst_n     (reset_n),
    .start_i   (ser_start),
    .run_i     (ser_run),
    .pixel_en_i(pixel_en),
    .line_buf_i(buf_q),
    .pixel_c_o (ser_pixel),
    .done_c_o  (ser_done)
  );

  assign rom_number = rom_number_q;
  assign rom_line   = rom_line_q;
  assign busy       = busy_q;
  assign pixel_out  = ser_run & ser_pixel;

endmodule

// File: doc/score_line_fetcher.md
Name: score_line_fetcher

Overview:
Scheduler for the combinational character ROM (4-bit number, 3-bit line in; 8-bit charline out, bit 0 = leftmost screen pixel).
- Each text scanline, fetches the charlines of NUM_CHARS score digits during horizontal blanking into a line buffer.
- Serialises the buffer as a 1-bit pixel stream during active video, with horizontal magnification.
- Sits between video timing and the colour mixer; the only master of the ROM address.

Parameters:
NUM_CHARS, 4, number of character slots per text line (1..8)
SCALE_LOG2, 1, each font pixel lasts 2**SCALE_LOG2 pixel_en strobes (0..3)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
line_start  input  1  one-cycle pulse at start of horizontal blanking
text_row  input  1  current scanline lies inside the text area; sampled with line_start
font_line  input  3  font row for this scanline; sampled with line_start
char_codes  input  4*NUM_CHARS  slot k code at bits [4k+3:4k]; slot 0 leftmost; sampled with line_start
display_start  input  1  one-cycle pulse: first text pixel of the line
pixel_en  input  1  pixel clock enable
rom_number  output  4  ROM number input
rom_line  output  3  ROM line input
rom_charline  input  8  ROM output, combinational from rom_number/rom_line
pixel_out  output  1  text pixel, valid while pixel_en
busy  output  1  high in FETCH or SHIFT

Behaviour:
- Reset (async assert, sync deassert): state IDLE; rom_number=0, rom_line=0, pixel_out=0, busy=0; line buffer cleared; all counters 0.
- States: IDLE, FETCH, READY, SHIFT.
- IDLE:
  - line_start && text_row: latch char_codes and font_line, slot counter=0, go FETCH.
  - line_start && !text_row: stay IDLE.
- FETCH:
  - rom_number = latched code of current slot; rom_line = latched font_line (both registered, driven from the FETCH entry cycle).
  - rom_charline is sampled into buffer[slot] one cycle after the address is presented.
  - Loads one slot per cycle; NUM_CHARS+1 cycles total from line_start to READY.
  - Codes 11..15 pass through unchanged; the ROM returns 8'hFF for them.
- READY: holds the buffer; on display_start go SHIFT with bit counter=0, slot counter=0, scale counter=0.
- SHIFT:
  - pixel_out = buffer[slot][bit] (bit 0 first), updated combinationally from the counters.
  - Counters advance only on pixel_en.
  - Scale counter wraps at 2**SCALE_LOG2 and advances the bit counter; bit wrap at 8 advances the slot.
  - After the last pixel-scale of slot NUM_CHARS-1, go IDLE.
  - Total duration: 8*NUM_CHARS*2**SCALE_LOG2 pixel_en strobes.
- pixel_out is 0 in every state except SHIFT.
- line_start in FETCH, READY or SHIFT: abort the current line; relatch inputs; restart FETCH if text_row, else go IDLE.
  - This includes line_start coinciding with the last SHIFT pixel: line_start wins.
- display_start outside READY: ignored; not queued.
- display_start and line_start in the same cycle: line_start wins.
- char_codes changes after line_start: no effect until the next line_start (no tearing).
- busy = (state==FETCH || state==SHIFT).

Optional Feature:
SCORE_BLANK_LEADING_ZERO_EN
- Defined: during FETCH, slots holding code 0 that precede the first non-zero slot are loaded as 8'h00 instead of the ROM data.
  - The last slot (NUM_CHARS-1) is never blanked.
  - Code 10 (smiley) counts as non-zero.
- Undefined: every slot is loaded from the ROM unchanged.

Decomposition:
- Package score_text_pkg holds:
  - the state enum type;
  - constants CHAR_W=8, CODE_W=4, LINE_W=3;
  - ROM_ERR_LINE=8'hFF.
- One natural sub-module: score_pixel_serializer.
  - Contains the slot/bit/scale counters and the pixel mux over the buffer.
  - Driven by start/pixel_en; reports done.
- The FSM and fetch logic stay in the top module.

Test Plan:
- Basic line: NUM_CHARS=4, SCALE_LOG2=0, codes {3,0,1,2} (slot0=2), font_line=3, text_row=1, line_start, then display_start with pixel_en every cycle.
  - Expect READY 5 cycles after line_start.
  - Expect 32 pixels matching ROM rows 19,11,3,27 (slot 0 first, LSB first), then IDLE with pixel_out=0.
- Scaling: SCALE_LOG2=2, pixel_en every 2nd cycle, code 8, font_line 0.
  - Expect each pixel held 4 strobes; 0 0 0 0 1 1 1 1 … pattern of 8'b01111110 reversed; 256 clock cycles in SHIFT.
- Abort: line_start with text_row=1 at SHIFT pixel 10.
  - Expect immediate pixel_out=0, new FETCH, then the new codes displayed on the next display_start.
- Ignored start: display_start during FETCH and in IDLE.
  - Expect no SHIFT and pixel_out=0.
  - Expect text_row=0 with line_start to keep busy=0.
- Error code and reset: code 4'hF.
  - Expect 8 ones for that slot.
  - Assert reset_n low mid-SHIFT: outputs 0 asynchronously, IDLE after release.
- With SCORE_BLANK_LEADING_ZERO_EN: codes slot0..3 = {0,0,5,0}.
  - Expect slots 0 and 1 dark, and slots 2 and 3 to show '5' and '0'.
  - Codes {0,0,0,0}: only slot 3 shows '0'.
